// File: rtl/sc_dff_chain.sv
// sc_dff_chain: scan-chain configuration register with built-in shift controller.
// A start request serially loads CHAIN_LEN bits from sc_in (first bit ends up in the MSB),
// then commits them in one cycle to a shadow register that drives cfg_q/cfg_qb.
// Optional feature macro: SC_CHAIN_PARITY_EN (adds par_exp/par_err and gates the commit on parity).
module sc_dff_chain #(
    parameter int unsigned          CHAIN_LEN = 32,
    parameter logic [CHAIN_LEN-1:0] RESET_VAL = '0,
    parameter int unsigned          CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sc_in,
`ifdef SC_CHAIN_PARITY_EN
    input  logic                 par_exp,
    output logic                 par_err,
`endif
    output logic                 sc_out,
    output logic [CHAIN_LEN-1:0] cfg_q,
    output logic [CHAIN_LEN-1:0] cfg_qb,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state_q;
    logic [CHAIN_LEN-1:0] shift_q;
    logic [CHAIN_LEN-1:0] shift_d;
    logic [CHAIN_LEN-1:0] shadow_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef SC_CHAIN_PARITY_EN
    logic                 par_acc_q;
    logic                 par_exp_q;
    logic                 par_err_q;
`endif

    // Next shift-register value for one scan step: shift toward the MSB, sc_in enters at bit 0.
    always_comb begin
        shift_d = {shift_q[CHAIN_LEN-2:0], sc_in};
    end

    // Load controller: IDLE -> SHIFT (CHAIN_LEN shifts) -> COMMIT -> IDLE, with registered busy/done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= RESET_VAL;
            shadow_q  <= RESET_VAL;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SC_CHAIN_PARITY_EN
            par_acc_q <= 1'b0;
            par_exp_q <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // abort is ignored here, so start wins when both are high.
                    if (start) begin
                        state_q   <= SHIFT;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
`ifdef SC_CHAIN_PARITY_EN
                        par_acc_q <= 1'b0;
                        par_exp_q <= par_exp;
                        par_err_q <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // An abort cycle does not shift; partial contents stay in shift_q.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        shift_q   <= shift_d;
                        cnt_q     <= cnt_q + 1'b1;
`ifdef SC_CHAIN_PARITY_EN
                        par_acc_q <= par_acc_q ^ sc_in;
`endif
                        if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                            state_q <= COMMIT;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
`ifdef SC_CHAIN_PARITY_EN
                    if (par_acc_q != par_exp_q) begin
                        par_err_q <= 1'b1;
                    end else begin
                        shadow_q  <= shift_q;
                        done_q    <= 1'b1;
                        par_err_q <= 1'b0;
                    end
`else
                    shadow_q <= shift_q;
                    done_q   <= 1'b1;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sc_out = shift_q[CHAIN_LEN-1];
    assign cfg_q  = shadow_q;
    assign cfg_qb = ~shadow_q;
    assign busy   = busy_q;
    assign done   = done_q;
`ifdef SC_CHAIN_PARITY_EN
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_sc_dff_chain.sv
// Scoreboard bench for sc_dff_chain (CHAIN_LEN=8): stimulus pushes expected committed words,
// an independent monitor pops them whenever done is seen and checks cfg_q/cfg_qb every cycle.
module tb_sc_dff_chain;
    localparam int N = 8;
    localparam logic [N-1:0] RV = 8'h00;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic         abort   = 1'b0;
    logic         sc_in   = 1'b0;
    logic         sc_out;
    logic [N-1:0] cfg_q;
    logic [N-1:0] cfg_qb;
    logic         busy;
    logic         done;
`ifdef SC_CHAIN_PARITY_EN
    logic         par_exp = 1'b0;
    logic         par_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] m_shift = RV;
    logic [N-1:0] cur_cfg = RV;

    sc_dff_chain #(
        .CHAIN_LEN(N),
        .RESET_VAL(RV),
        .CNT_W(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .abort  (abort),
        .sc_in  (sc_in),
`ifdef SC_CHAIN_PARITY_EN
        .par_exp(par_exp),
        .par_err(par_err),
`endif
        .sc_out (sc_out),
        .cfg_q  (cfg_q),
        .cfg_qb (cfg_qb),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on every done, and require cfg_q to hold the last committed word otherwise.
    initial begin
        logic [N-1:0] inv;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cur_cfg = RV;
            end else if (done) begin
                if (exp_q.size() == 0) chk("spurious_done", done, 0);
                else cur_cfg = exp_q.pop_front();
            end
            inv = ~cur_cfg;
            chk("cfg_q", cfg_q, cur_cfg);
            chk("cfg_qb", cfg_qb, inv);
        end
    end

    // One load attempt: word w is sent MSB first. Index -1 disables abort/spurious start/reset.
    task automatic load(input logic [N-1:0] w, input int abort_at, input int spur_at,
                        input int rst_at, input bit noise);
        @(negedge clk);
        start = 1'b1;
        abort = noise;
`ifdef SC_CHAIN_PARITY_EN
        par_exp = ^w;
`endif
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < N; i++) begin
            sc_in = w[N-1-i];
            start = (i == spur_at);
            abort = (i == abort_at);
            if (i == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_cfg_q", cfg_q, RV);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_sc_out", sc_out, RV[N-1]);
                m_shift = RV;
                start = 1'b0;
                abort = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #2 reset_n = 1'b1;
                return;
            end
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (i == abort_at) begin
                chk("abort_busy", busy, 0);
                chk("abort_sc_out", sc_out, m_shift[N-1]);
                return;
            end
            m_shift = {m_shift[N-2:0], w[N-1-i]};
            chk("sc_out", sc_out, m_shift[N-1]);
            chk("busy_shift", busy, (i != N-1));
        end
        exp_q.push_back(w);
        // start/abort during the commit cycle must be ignored.
        start = noise;
        abort = noise;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("done_latency", done, 1);
        chk("busy_commit", busy, 0);
`ifdef SC_CHAIN_PARITY_EN
        chk("par_err_ok", par_err, 0);
`endif
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] w;
        int ab, sp, rs;
        #12;
        chk("reset_cfg_q", cfg_q, 8'h00);
        chk("reset_cfg_qb", cfg_qb, 8'hFF);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sc_out", sc_out, RV[N-1]);
        @(negedge clk);
        #2 reset_n = 1'b1;

        load(8'hB2, -1, -1, -1, 1'b0);   // bits 1,0,1,1,0,0,1,0
        chk("directed_b2", cfg_q, 8'hB2);
        load(8'hB2, -1, 3, -1, 1'b0);    // spurious start in SHIFT
        load(8'h5C, 4, -1, -1, 1'b0);    // aborted after 4 bits
        chk("abort_keeps_cfg", cfg_q, 8'hB2);
        load(8'h3D, -1, -1, 5, 1'b0);    // reset mid-load
        load(8'hA7, -1, -1, -1, 1'b1);   // full load after reset, commit-cycle noise

        for (int n = 0; n < 40; n++) begin
            w  = N'($urandom);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N-1)) : -1;
            sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N-1)) : -1;
            rs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, N-1)) : -1;
            load(w, ab, sp, rs, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
